// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter
//   Two-requester arbiter in front of an asynchronous SRAM. Each granted access
//   runs SETUP (1 cycle) -> STROBE (STROBE_CYC cycles) -> HOLD (1 cycle) and
//   then returns to IDLE. Ties are broken round-robin. Requester 0 wins the
//   first tie after reset.
//
// Ports
//   clk                 sole clock, rising edge
//   _reset              asynchronous active-low reset
//   req0/req1           level requests, held until the matching done
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         requester addresses
//   wdata0/wdata1       requester write data
//   done0/done1         one-cycle completion pulse (HOLD cycle)
//   rdata               data of the last completed read
//   busy                high whenever not IDLE
//   _ram_cs/_ram_oe/_ram_w  active-low RAM controls
//   ram_addr/ram_din    RAM address / write data, driven from the request latch
//   ram_dout            RAM read data
module main_ram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              _ram_cs,
  output logic              _ram_oe,
  output logic              _ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  // Counter counts down the remaining strobe cycles; loaded with STROBE_CYC-1.
  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

  state_e              state_q, state_d;
  logic                gnt_q,   gnt_d;    // requester currently served
  logic                last_q,  last_d;   // requester served last
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                pick;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          // Sample read data while _ram_oe is still low.
          if (!we_q) rdata_d = ram_dout;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controls decode straight from the state register so an asynchronous reset
  // releases the strobes without waiting for a clock edge.
  assign busy     = (state_q != S_IDLE);
  assign _ram_cs  = (state_q == S_IDLE);
  assign _ram_w   = !((state_q == S_STROBE) &&  we_q);
  assign _ram_oe  = !((state_q == S_STROBE) && !we_q);
  assign done0    = (state_q == S_HOLD) && !gnt_q;
  assign done1    = (state_q == S_HOLD) &&  gnt_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Testbench for main_ram_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (elapsed cycles since grant).
module tb_main_ram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned S  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, busy, ram_cs_n, ram_oe_n, ram_w_n;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  main_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S)) dut (
    .clk(clk), ._reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    ._ram_cs(ram_cs_n), ._ram_oe(ram_oe_n), ._ram_w(ram_w_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Simple SRAM model: writes land on clock edges while the write strobe is low.
  logic [DW-1:0] mem [16];
  logic          mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (!ram_cs_n && !ram_w_n) begin
      mem[ram_addr[3:0]] <= ram_din;
    end
  end
  assign ram_dout = !ram_oe_n ? mem[ram_addr[3:0]] : 8'hEE;

  // Reference model state
  bit            pend [2];
  bit            keep [2];
  bit            pwe  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pdata[2];
  int unsigned   el;          // 0 = idle, else cycles elapsed since grant
  bit            cur, last, l_we, rnd;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data, exp_rdata;
  logic [DW-1:0] ref_mem [16];

  task automatic model_reset();
    el = 0; last = 1'b1; cur = 1'b0; l_we = 1'b0; l_addr = '0; l_data = '0;
    exp_rdata = '0;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; keep[i] = 1'b0; end
  endtask

  task automatic drive_inputs();
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit            w [2];
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && !(el != 0 && cur == 1'(i))) begin
        a[i] = paddr[i]; d[i] = pdata[i]; w[i] = pwe[i];
      end else begin
        a[i] = AW'($urandom); d[i] = DW'($urandom); w[i] = 1'($urandom);
      end
    end
    req0 = pend[0]; we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
    req1 = pend[1]; we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
  endtask

  // One clock: update the model at the edge, drive new inputs, return at negedge.
  task automatic step();
    @(posedge clk);
    if (el == 0) begin
      if (pend[0] || pend[1]) begin
        cur    = (pend[0] && pend[1]) ? !last : pend[1];
        last   = cur;
        l_we   = pwe[cur];
        l_addr = paddr[cur];
        l_data = pdata[cur];
        el     = 1;
      end
    end else if (el == S + 2) begin
      pend[cur] = keep[cur];
      el = 0;
    end else begin
      if (el == S + 1) begin
        if (l_we) ref_mem[l_addr[3:0]] = l_data;
        else      exp_rdata = ref_mem[l_addr[3:0]];
      end
      el++;
    end
    #1;
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom_range(0, 1));
          paddr[i] = AW'($urandom_range(0, 15));
          pdata[i] = DW'($urandom);
        end
      end
    end
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_clr = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    drive_inputs();
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    tests++; if ({ram_cs_n, ram_oe_n, ram_w_n} !== 3'b111) begin fails++; $display("FAIL rst_strobes got=%b want=111", {ram_cs_n, ram_oe_n, ram_w_n}); end
    tests++; if ({done0, done1, busy} !== 3'b000) begin fails++; $display("FAIL rst_done_busy got=%b want=000", {done0, done1, busy}); end
    tests++; if (rdata !== '0) begin fails++; $display("FAIL rst_rdata got=%h want=00", rdata); end
    tests++; if (ram_addr !== '0 || ram_din !== '0) begin fails++; $display("FAIL rst_addr_din got=%h/%h want=0/0", ram_addr, ram_din); end
    rst_n = 1'b1;
    step();
    tests++; if (busy !== 1'b0 || ram_cs_n !== 1'b1) begin fails++; $display("FAIL rst_idle busy=%b cs=%b want=0/1", busy, ram_cs_n); end
  endtask

  task automatic test_write();
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'd5; pdata[0] = 8'hA5;
    drive_inputs();
    for (int unsigned n = 1; n <= S + 2; n++) begin
      step();
      tests++; if (ram_cs_n !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wr_cs_busy n=%0d cs=%b busy=%b want=0/1", n, ram_cs_n, busy); end
      tests++; if (ram_w_n !== !(n >= 2 && n <= S + 1)) begin fails++; $display("FAIL wr_w n=%0d got=%b want=%b", n, ram_w_n, !(n >= 2 && n <= S + 1)); end
      tests++; if (ram_oe_n !== 1'b1) begin fails++; $display("FAIL wr_oe n=%0d got=%b want=1", n, ram_oe_n); end
      tests++; if (done0 !== (n == S + 2) || done1 !== 1'b0) begin fails++; $display("FAIL wr_done n=%0d got=%b%b want=%b0", n, done0, done1, n == S + 2); end
      tests++; if (ram_addr !== 20'd5 || ram_din !== 8'hA5) begin fails++; $display("FAIL wr_bus n=%0d got=%h/%h want=5/a5", n, ram_addr, ram_din); end
    end
    step();
    tests++; if (busy !== 1'b0 || done0 !== 1'b0) begin fails++; $display("FAIL wr_end busy=%b done0=%b want=0/0", busy, done0); end
    tests++; if (mem[5] !== 8'hA5) begin fails++; $display("FAIL wr_mem got=%h want=a5", mem[5]); end
  endtask

  task automatic test_read();
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 20'd5; pdata[1] = 8'h3C;
    drive_inputs();
    for (int unsigned n = 1; n <= S + 2; n++) begin
      step();
      tests++; if (ram_oe_n !== !(n >= 2 && n <= S + 1)) begin fails++; $display("FAIL rd_oe n=%0d got=%b want=%b", n, ram_oe_n, !(n >= 2 && n <= S + 1)); end
      tests++; if (ram_w_n !== 1'b1) begin fails++; $display("FAIL rd_w n=%0d got=%b want=1", n, ram_w_n); end
      tests++; if (done1 !== (n == S + 2) || done0 !== 1'b0) begin fails++; $display("FAIL rd_done n=%0d got=%b%b want=0%b", n, done0, done1, n == S + 2); end
    end
    tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL rd_data got=%h want=a5", rdata); end
    step();
  endtask

  task automatic test_tie();
    int order [4];
    int got = 0;
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'd1; pdata[0] = 8'h11;
    pend[1] = 1'b1; pwe[1] = 1'b1; paddr[1] = 20'd2; pdata[1] = 8'h22;
    apply_reset();
    pend[0] = 1'b1; pend[1] = 1'b1; keep[0] = 1'b1; keep[1] = 1'b1;
    drive_inputs();
    for (int c = 0; c < 60 && got < 4; c++) begin
      step();
      tests++; if (done0 && done1) begin fails++; $display("FAIL tie_both_done got=11 want=not both"); end
      if (done0) begin order[got] = 0; got++; end
      else if (done1) begin order[got] = 1; got++; end
    end
    tests++; if (got !== 4) begin fails++; $display("FAIL tie_timeout got=%0d want=4 completions", got); end
    for (int k = 0; k < got; k++) begin
      tests++; if (order[k] !== k % 2) begin fails++; $display("FAIL tie_order k=%0d got=%0d want=%0d", k, order[k], k % 2); end
    end
    keep[0] = 1'b0; keep[1] = 1'b0;
    for (int c = 0; c < 30 && (el != 0 || pend[0] || pend[1]); c++) step();
    step();
    tests++; if (mem[1] !== 8'h11 || mem[2] !== 8'h22) begin fails++; $display("FAIL tie_mem got=%h/%h want=11/22", mem[1], mem[2]); end
  endtask

  task automatic test_holdoff();
    int t0 = -1, t1 = -1, idle = 0;
    logic [DW-1:0] rd = '0;
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'd3; pdata[0] = 8'h33;
    drive_inputs();
    for (int c = 0; c < 20 && el != 2; c++) step();
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 20'd3; pdata[1] = 8'h00;
    drive_inputs();
    for (int c = 0; c < 30 && t1 < 0; c++) begin
      step();
      if (done0 && t0 < 0) t0 = c;
      if (done1) begin t1 = c; rd = rdata; end
      if (t0 >= 0 && t1 < 0 && !busy) idle++;
    end
    tests++; if (t0 < 0 || t1 < 0) begin fails++; $display("FAIL hold_timeout t0=%0d t1=%0d want both >=0", t0, t1); end
    tests++; if (t1 - t0 !== int'(S) + 3) begin fails++; $display("FAIL hold_spacing got=%0d want=%0d", t1 - t0, S + 3); end
    tests++; if (idle !== 1) begin fails++; $display("FAIL hold_idle got=%0d want=1", idle); end
    tests++; if (rd !== 8'h33) begin fails++; $display("FAIL hold_rdata got=%h want=33", rd); end
    step();
  endtask

  task automatic test_reset_mid();
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'd9; pdata[0] = 8'h99;
    drive_inputs();
    for (int c = 0; c < 20 && el != 2; c++) step();
    tests++; if (ram_w_n !== 1'b0) begin fails++; $display("FAIL rmid_strobe got=%b want=0", ram_w_n); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if ({ram_cs_n, ram_oe_n, ram_w_n} !== 3'b111) begin fails++; $display("FAIL rmid_async got=%b want=111", {ram_cs_n, ram_oe_n, ram_w_n}); end
    tests++; if ({done0, done1, busy} !== 3'b000) begin fails++; $display("FAIL rmid_done_busy got=%b want=000", {done0, done1, busy}); end
    tests++; if (rdata !== '0) begin fails++; $display("FAIL rmid_rdata got=%h want=00", rdata); end
    drive_inputs();
    repeat (2) begin
      @(negedge clk);
      tests++; if ({done0, done1, busy} !== 3'b000) begin fails++; $display("FAIL rmid_held got=%b want=000", {done0, done1, busy}); end
    end
    rst_n = 1'b1;
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 20'd5;
    drive_inputs();
    for (int unsigned n = 1; n <= S + 2; n++) begin
      step();
      tests++; if (done1 !== (n == S + 2)) begin fails++; $display("FAIL rmid_done1 n=%0d got=%b want=%b", n, done1, n == S + 2); end
    end
    tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL rmid_read got=%h want=a5", rdata); end
    tests++; if (mem[9] !== 8'h00) begin fails++; $display("FAIL rmid_mem got=%h want=00", mem[9]); end
    step();
  endtask

  task automatic test_random();
    bit strobe;
    rnd = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      strobe = (el >= 2 && el <= S + 1);
      tests++; if (done0 !== (el == S + 2 && !cur) || done1 !== (el == S + 2 && cur)) begin fails++; $display("FAIL rnd_done c=%0d got=%b%b want=%b%b", c, done0, done1, el == S + 2 && !cur, el == S + 2 && cur); end
      tests++; if (busy !== (el != 0) || ram_cs_n !== (el == 0)) begin fails++; $display("FAIL rnd_busy_cs c=%0d got=%b/%b want=%b/%b", c, busy, ram_cs_n, el != 0, el == 0); end
      tests++; if (ram_w_n !== !(strobe && l_we)) begin fails++; $display("FAIL rnd_w c=%0d got=%b want=%b", c, ram_w_n, !(strobe && l_we)); end
      tests++; if (ram_oe_n !== !(strobe && !l_we)) begin fails++; $display("FAIL rnd_oe c=%0d got=%b want=%b", c, ram_oe_n, !(strobe && !l_we)); end
      tests++; if (!ram_w_n && !ram_oe_n) begin fails++; $display("FAIL rnd_both_low c=%0d got=00 want=not both low", c); end
      tests++; if (ram_addr !== l_addr || ram_din !== l_data) begin fails++; $display("FAIL rnd_bus c=%0d got=%h/%h want=%h/%h", c, ram_addr, ram_din, l_addr, l_data); end
      tests++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rdata, exp_rdata); end
    end
    rnd = 1'b0;
    for (int c = 0; c < 40 && (el != 0 || pend[0] || pend[1]); c++) step();
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd_drain busy=%b want=0", busy); end
  endtask

  initial begin
    rnd = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_holdoff();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
